// File: rtl/riscv_top.sv
// Multicycle RV32I-subset core (LUI, OP, OP-IMM, LW, SW, BEQ, JAL) over one unified word-addressed memory.
// Instructions take 2 to 5 cycles through the control FSM; the core has no ports beyond clock and reset.
module riscv_top #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic reset
);
  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [5:0] S_FETCH    = 6'd0;
  localparam logic [5:0] S_DECODE   = 6'd1;
  localparam logic [5:0] S_LUI      = 6'd2;
  localparam logic [5:0] S_EXECUTER = 6'd3;
  localparam logic [5:0] S_EXECUTEI = 6'd4;
  localparam logic [5:0] S_ALUWB    = 6'd5;
  localparam logic [5:0] S_MEMADR   = 6'd6;
  localparam logic [5:0] S_MEMREAD  = 6'd7;
  localparam logic [5:0] S_MEMWB    = 6'd8;
  localparam logic [5:0] S_MEMWRITE = 6'd9;
  localparam logic [5:0] S_BEQ      = 6'd10;
  localparam logic [5:0] S_JAL      = 6'd11;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  logic [31:0] M     [0:MEM_WORDS-1];
  logic [31:0] RFMem [0:31];
  logic [31:0] PC, IR;
  logic [5:0]  state, state_d;
  logic [31:0] old_pc_q, a_q, b_q, alu_out_q, data_q;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_ext, src_a, src_b, alu_res, rf_a, rf_b, rf_wd;
  logic [3:0]  alu_ctl;
  logic        rf_we, mem_we;

  // Indices past the end of the array read as zero.
  function automatic logic [31:0] mem_read(input logic [29:0] widx);
    if ({2'b00, widx} < MEM_WORDS) return M[widx[AW-1:0]];
    return 32'h0;
  endfunction

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  assign opcode = IR[6:0];
  assign rd     = IR[11:7];
  assign funct3 = IR[14:12];
  assign rs1    = IR[19:15];
  assign rs2    = IR[24:20];
  assign rf_a   = (rs1 == 5'd0) ? 32'h0 : RFMem[rs1];
  assign rf_b   = (rs2 == 5'd0) ? 32'h0 : RFMem[rs2];

  always_comb begin
    case (opcode)
      OP_LUI:  imm_ext = {IR[31:12], 12'h000};
      OP_SW:   imm_ext = {{20{IR[31]}}, IR[31:25], IR[11:7]};
      OP_BEQ:  imm_ext = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
      OP_JAL:  imm_ext = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
      default: imm_ext = {{20{IR[31]}}, IR[31:20]};
    endcase
  end

  always_comb begin
    src_a   = a_q;
    src_b   = b_q;
    alu_ctl = ALU_ADD;
    case (state)
      S_LUI:      begin src_a = 32'h0; src_b = imm_ext; end
      S_EXECUTER: alu_ctl = alu_op(funct3, IR[30]);
      // Bit 30 of an immediate is only an opcode modifier for srai.
      S_EXECUTEI: begin src_b = imm_ext; alu_ctl = alu_op(funct3, IR[30] && (funct3 == 3'b101)); end
      S_MEMADR:   src_b = imm_ext;
      S_BEQ:      alu_ctl = ALU_SUB;
      default:    ;
    endcase
  end

  always_comb begin
    case (alu_ctl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLL:  alu_res = src_a << src_b[4:0];
      ALU_SRL:  alu_res = src_a >> src_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> src_b[4:0]);
      ALU_SLTU: alu_res = {31'b0, src_a < src_b};
      default:  alu_res = 32'h0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LUI:       state_d = S_LUI;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_LUI, S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      PC        <= RESET_PC;
      IR        <= 32'h0;
      old_pc_q  <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_out_q <= 32'h0;
      data_q    <= 32'h0;
    end else begin
      state <= state_d;
      case (state)
        S_FETCH: begin
          IR       <= mem_read(PC[31:2]);
          PC       <= PC + 32'd4;
          old_pc_q <= PC;
        end
        S_DECODE:  begin a_q <= rf_a; b_q <= rf_b; end
        S_LUI, S_EXECUTER, S_EXECUTEI, S_MEMADR: alu_out_q <= alu_res;
        S_MEMREAD: data_q <= mem_read(alu_out_q[31:2]);
        S_BEQ:     if (alu_res == 32'h0) PC <= old_pc_q + imm_ext;
        S_JAL:     PC <= old_pc_q + imm_ext;
        default:   ;
      endcase
    end
  end

  // Write enables also require reset high, so an aborted instruction leaves no trace.
  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_out_q;
    case (state)
      S_ALUWB: rf_we = 1'b1;
      S_MEMWB: begin rf_we = 1'b1; rf_wd = data_q; end
      S_JAL:   begin rf_we = 1'b1; rf_wd = old_pc_q + 32'd4; end
      default: ;
    endcase
    rf_we  = rf_we && reset && (rd != 5'd0);
    mem_we = reset && (state == S_MEMWRITE) && ({2'b00, alu_out_q[31:2]} < MEM_WORDS);
  end

  always_ff @(posedge clk) begin
    if (rf_we) RFMem[rd] <= rf_wd;
  end

  always_ff @(posedge clk) begin
    if (mem_we) M[alu_out_q[AW+1:2]] <= b_q;
  end

endmodule

// File: tb/tb_riscv_top.sv
// Bench for riscv_top: preloads memory hierarchically, runs directed and random programs against an ISA-level model.
// Each retired instruction's PC, cycle count and architectural effect is compared by a monitor against a scoreboard queue.
module tb_riscv_top;
  localparam int MW = 256;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  riscv_top #(.MEM_WORDS(MW), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset));

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  kind;    // 0 none, 1 register write, 2 memory write
    logic [7:0]  idx;
    logic [31:0] val;
    logic [3:0]  cycles;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] rf  [0:31];
  logic [31:0] mem [0:MW-1];
  logic [31:0] mpc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // ---------------- ISA-level reference model ----------------
  function automatic logic [31:0] mrd(input logic [31:0] addr);
    int w;
    w = int'(addr[31:2]);
    if (w < MW) return mem[w];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_step(output exp_t e);
    logic [31:0] ins, a, b, res, npc, addr, i_i, i_s, i_b, i_j;
    logic        wr;
    int          w;
    ins = mrd(mpc);
    a   = rf[ins[19:15]];
    b   = rf[ins[24:20]];
    i_i = {{20{ins[31]}}, ins[31:20]};
    i_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    i_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    i_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = mpc + 32'd4;
    wr  = 1'b0;
    res = 32'h0;
    e   = '0;
    e.cycles = 4'd2;
    case (ins[6:0])
      7'b0110111: begin res = {ins[31:12], 12'h000}; wr = 1'b1; e.cycles = 4'd4; end
      7'b0110011: begin res = ref_alu(ins[14:12], ins[30], a, b); wr = 1'b1; e.cycles = 4'd4; end
      7'b0010011: begin
        res = ref_alu(ins[14:12], ins[30] && (ins[14:12] == 3'd5), a, i_i);
        wr = 1'b1; e.cycles = 4'd4;
      end
      7'b0000011: begin addr = a + i_i; res = mrd(addr); wr = 1'b1; e.cycles = 4'd5; end
      7'b0100011: begin
        addr = a + i_s; e.cycles = 4'd4;
        w = int'(addr[31:2]);
        if (w < MW) begin mem[w] = b; e.kind = 2'd2; e.idx = addr[9:2]; e.val = b; end
      end
      7'b1100011: begin e.cycles = 4'd3; if (a == b) npc = mpc + i_b; end
      7'b1101111: begin e.cycles = 4'd3; res = mpc + 32'd4; wr = 1'b1; npc = mpc + i_j; end
      default: ;
    endcase
    if (wr) begin
      if (ins[11:7] != 5'd0) rf[ins[11:7]] = res;
      e.kind = 2'd1;
      e.idx  = {3'b000, ins[11:7]};
      e.val  = rf[ins[11:7]];
    end
    mpc  = npc;
    e.pc = npc;
  endtask

  task automatic run_model(input int max_steps, input logic [31:0] stop_pc);
    exp_t e;
    int   n;
    n = 0;
    while (n < max_steps && mpc < stop_pc) begin
      model_step(e);
      expq.push_back(e);
      n++;
    end
  endtask

  // ---------------- monitor: one comparison set per retired instruction ----------------
  logic prev_fetch = 1'b1;
  int   cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_fetch = 1'b1;
      cyc = 0;
    end else begin
      cyc++;
      if (dut.state == dut.S_FETCH && !prev_fetch) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("retire_pc", dut.PC, e.pc);
          chk("retire_cycles", 32'(cyc), 32'(e.cycles));
          if (e.kind == 2'd1) chk("retire_reg", dut.RFMem[e.idx[4:0]], e.val);
          if (e.kind == 2'd2) chk("retire_mem", dut.M[e.idx], e.val);
        end
        cyc = 0;
      end
      prev_fetch = (dut.state == dut.S_FETCH);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input int i, input logic [31:0] v);
    mem[i]   = v;
    dut.M[i] = v;
  endtask

  task automatic init_all;
    logic [31:0] v;
    reset = 1'b0;
    #3;
    expq.delete();
    for (int i = 0; i < MW; i++) put(i, 32'h0);
    for (int i = 0; i < 32; i++) begin
      v = (i == 0) ? 32'h0 : $urandom;
      rf[i] = v;
      dut.RFMem[i] = v;
    end
    mpc = 32'h0;
  endtask

  task automatic release_reset;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 4000 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: %0d retirements still pending, required 0", expq.size());
      expq.delete();
    end
    #1;
  endtask

  function automatic logic [11:0] mem_off();
    if ($urandom_range(0, 7) == 0) return 12'h7fc;
    return 12'(12'h200 + 4 * $urandom_range(0, 63) + $urandom_range(0, 3));
  endfunction

  task automatic gen_random(input int len);
    logic [31:0] ins;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] im;
    for (int i = 128; i < 192; i++) put(i, $urandom);
    for (int i = 0; i < len; i++) begin
      rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
      f3 = 3'($urandom); im = 12'($urandom);
      case ($urandom_range(0, 8))
        0: ins = enc_u(20'($urandom), rd);
        1: ins = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0,
                       r2, r1, f3, rd);
        2, 8: begin
          if (f3 == 3'd1) im = {7'b0, im[4:0]};
          if (f3 == 3'd5) im = {($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0, im[4:0]};
          ins = enc_i(im, r1, f3, rd, 7'b0010011);
        end
        3: ins = enc_i(mem_off(), 5'd0, 3'b010, rd, 7'b0000011);
        4: ins = enc_s(mem_off(), r2, 5'd0);
        5: ins = enc_b(($urandom_range(0, 1) == 1) ? 13'd8 : 13'd12, r1,
                       ($urandom_range(0, 1) == 1) ? r1 : r2);
        6: ins = enc_j(21'd8, rd);
        default: ins = {25'($urandom), 7'b0001111};
      endcase
      put(i, ins);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Directed program: LUIs, addi/sub, taken beq, sw/lw, out-of-reach x0 write, backward jal.
    init_all();
    put(0,  32'h000140b7);
    put(1,  32'h000c8137);
    put(2,  32'h003ff1b7);
    put(3,  enc_i(12'hfff, 5'd0, 3'b000, 5'd5, 7'b0010011));
    put(4,  enc_b(13'd8, 5'd0, 5'd0));
    put(5,  enc_i(12'd77, 5'd0, 3'b000, 5'd4, 7'b0010011));
    put(6,  enc_r(7'b0100000, 5'd5, 5'd0, 3'b000, 5'd6));
    put(7,  enc_s(12'h0a8, 5'd3, 5'd0));
    put(8,  enc_i(12'h0a8, 5'd0, 3'b010, 5'd7, 7'b0000011));
    put(9,  enc_i(12'h0a0, 5'd0, 3'b010, 5'd8, 7'b0000011));
    put(10, enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011));
    put(11, enc_j(-21'sd16, 5'd9));
    put(40, 32'hbadab00f);
    run_model(11, 32'hffff_ffff);
    chk("reset_state", 32'(dut.state), 32'(dut.S_FETCH));
    chk("reset_pc", dut.PC, 32'h0);
    chk("reset_ir", dut.IR, 32'h0);
    release_reset();
    @(posedge clk);
    #1;
    chk("first_state", 32'(dut.state), 32'(dut.S_DECODE));
    chk("first_ir", dut.IR, 32'h000140b7);
    chk("first_pc", dut.PC, 32'h4);
    wait_drain();
    chk("x0", dut.RFMem[0], 32'h0);
    chk("x1", dut.RFMem[1], 32'h00014000);
    chk("x2", dut.RFMem[2], 32'h000c8000);
    chk("x3", dut.RFMem[3], 32'h003ff000);
    chk("x5", dut.RFMem[5], 32'hffffffff);
    chk("x6", dut.RFMem[6], 32'h00000001);
    chk("x7", dut.RFMem[7], 32'h003ff000);
    chk("x8", dut.RFMem[8], 32'hbadab00f);
    chk("x9_link", dut.RFMem[9], 32'h00000030);
    chk("m42", dut.M[42], 32'h003ff000);

    // Reset pulsed while an addi sits in ALUWB must abort the write.
    init_all();
    put(0, enc_i(12'd123, 5'd0, 3'b000, 5'd10, 7'b0010011));
    dut.RFMem[10] = 32'h5a5a5a5a;
    release_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_aluwb", 32'(dut.state), 32'(dut.S_ALUWB));
    reset = 1'b0;
    #1;
    chk("abort_state", 32'(dut.state), 32'(dut.S_FETCH));
    chk("abort_pc", dut.PC, 32'h0);
    chk("abort_ir", dut.IR, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_x10", dut.RFMem[10], 32'h5a5a5a5a);
    release_reset();
    @(posedge clk);
    #1;
    chk("rerelease_state", 32'(dut.state), 32'(dut.S_DECODE));

    // Random straight-line programs with forward branches and jumps.
    for (int p = 0; p < 8; p++) begin
      init_all();
      gen_random(40);
      run_model(200, 32'd160);
      release_reset();
      wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_top.md
RISCV_TOP -- requirements
Module: riscv_top

Interface
REQ-001 Parameter MEM_WORDS, default 256: number of 32-bit words in the unified instruction/data memory.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 No other ports; memory array M, register file RFMem[0:31], PC, IR and FSM state are internal, hierarchically accessible storage.

Function
REQ-006 Multicycle RV32I subset core: LUI, OP (add, sub, and, or, xor, slt, sltu, sll, srl, sra), OP-IMM (same minus sub), LW, SW, BEQ, JAL.
REQ-007 Memory is word-addressed: M[addr[31:2]]; byte-offset bits are ignored; one shared array serves fetch and data.
REQ-008 Control FSM states, 6-bit encoding: FETCH, DECODE, LUI, EXECUTER, EXECUTEI, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE, BEQ, JAL.
REQ-009 FETCH: at the exiting edge, IR <= M[PC>>2] and PC <= PC+4; OldPC <= PC; next state DECODE.
REQ-010 DECODE: opcode = IR[6:0], rd = IR[11:7], rs1/rs2 fields decoded combinationally from IR; operands A/B registered from the register file at the exiting edge.
REQ-011 Immediate extender: I-type sign-extend IR[31:20]; S-type {IR[31:25],IR[11:7]}; B-type {IR[31],IR[7],IR[30:25],IR[11:8],0}; J-type {IR[31],IR[19:12],IR[20],IR[30:21],0}; U-type {IR[31:12],12'h000}.
REQ-012 DECODE transitions by opcode: 0110111->LUI, 0110011->EXECUTER, 0010011->EXECUTEI, 0000011/0100011->MEMADR, 1100011->BEQ, 1101111->JAL; any other opcode -> FETCH (NOP).
REQ-013 LUI: ALU srcA = 32'h0, srcB = imm_ext, ALUControl = 4'b0000 (ADD); ALUOut latched at exit; next ALUWB.
REQ-014 ALUControl encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU; shifts use srcB[4:0]; ALU result is combinational.
REQ-015 EXECUTER: srcA=A, srcB=B, operation from funct3/funct7[5]; EXECUTEI: srcB=imm_ext, funct7[5] honoured only for srai; both -> ALUWB.
REQ-016 ALUWB: RFMem[rd] <= ALUOut at exiting edge; next FETCH; the written value is visible during that FETCH.
REQ-017 Writes to x0 are discarded; RFMem[0] always reads 0.
REQ-018 MEMADR: ALUOut <= A + imm_ext; lw -> MEMREAD, sw -> MEMWRITE.
REQ-019 MEMREAD: Data <= M[ALUOut>>2]; -> MEMWB; MEMWB: RFMem[rd] <= Data; -> FETCH.
REQ-020 MEMWRITE: M[ALUOut>>2] <= B; -> FETCH.
REQ-021 BEQ: ALU computes A-B; if zero, PC <= OldPC + imm_ext; -> FETCH.
REQ-022 JAL: RFMem[rd] <= OldPC+4, PC <= OldPC + imm_ext; -> FETCH.
REQ-023 Out-of-range memory index reads return 0; out-of-range writes are ignored.

Reset
REQ-024 While reset is low: state = FETCH, PC = RESET_PC, IR = 0; registers and memory contents unaffected.
REQ-025 Reset asserted mid-instruction aborts it immediately with no pending register or memory write; first rising edge after release executes FETCH (state DECODE follows).

Verification
REQ-026 M[0]=32'h000140b7, reset released -> DECODE: opcode 0110111, imm_ext 32'h00014000; LUI: srcA 0, srcB 32'h00014000, ALUControl 0, result 32'h00014000; ALUWB: rd 1; next FETCH: x1=32'h00014000.
REQ-027 Follow with M[1]=32'h000c8137, M[2]=32'h003ff1b7 -> x2=32'h000c8000, x3=32'h003ff000, each instruction taking exactly FETCH, DECODE, LUI, ALUWB (4 cycles).
REQ-028 addi x5,x0,-1 then sub x6,x0,x5 -> x5=32'hFFFFFFFF, x6=1; addi x0,x0,5 leaves x0=0.
REQ-029 sw x3,0xa8(x0) then lw x7,0xa8(x0) -> M[42]=32'h003ff000, x7=32'h003ff000; lw from M[40]=32'hbadab00f returns 32'hbadab00f.
REQ-030 beq x0,x0,+8 at PC 0x10 -> next fetch at 0x18; jal x1,-16 at 0x20 -> x1=0x24, next fetch at 0x10.
REQ-031 Reset pulsed low during ALUWB -> target register unchanged, state FETCH, PC=0.
